// File: rtl/cpu_run_pkg.sv
// ----------------------------------------------------------------------------
// cpu_run_pkg
// Shared definitions for the CPU run controller: the controller state
// encoding and the default values of its timing parameters.
// ----------------------------------------------------------------------------
package cpu_run_pkg;

    // Controller states; all four are reachable on every run.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } run_state_t;

    localparam int unsigned DEF_PULSE_CYCLES   = 32'd1;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1024;
    localparam int unsigned DEF_CNT_W          = 32'd16;

endpackage : cpu_run_pkg

// File: rtl/cpu_run_ctrl_timer.sv
// ----------------------------------------------------------------------------
// run_timer
// Cycle counter shared by the start-pulse width and the completion wait.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   i_clear      force the count to 0 (highest priority)
//   i_load       force the count to 1 (first cycle of a new interval)
//   i_en         increment the count
//   i_tc_val     terminal-count value to compare against
//   o_count      current count
//   o_tc         count equals i_tc_val
// ----------------------------------------------------------------------------
module run_timer
    import cpu_run_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Counter register: clear beats load, load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_ONE;
        end else if (i_en) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tc_val);

endmodule : run_timer

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
// Starts a CPU run with a fixed-width start pulse, waits for the CPU's done
// flag with a timeout, and reports the outcome and wait length.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   i_go            run request, only looked at while idle
//   i_cpu_done      completion flag from the CPU
//   o_cpu_start     start pulse to the CPU, PULSE_CYCLES clocks wide
//   o_busy          high whenever a run is in progress (not idle)
//   o_run_ok        one-clock pulse: CPU reported done
//   o_run_timeout   one-clock pulse: run abandoned after TIMEOUT_CYCLES
//   o_cycles        wait length of the last finished run
//   o_runs          finished-run count, wraps at 256
// ----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_go,
    input  logic             i_cpu_done,
    output logic             o_cpu_start,
    output logic             o_busy,
    output logic             o_run_ok,
    output logic             o_run_timeout,
    output logic [CNT_W-1:0] o_cycles,
    output logic [7:0]       o_runs
);

    localparam logic [CNT_W-1:0] PULSE_TC   = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES);

    run_state_t       r_state;
    logic             r_cpu_start;
    logic             r_busy;
    logic             r_run_ok;
    logic             r_run_timeout;
    logic [CNT_W-1:0] r_cycles;
    logic [7:0]       r_runs;

    logic             w_load;
    logic             w_en;
    logic             w_clear;
    logic [CNT_W-1:0] w_tc_val;
    logic [CNT_W-1:0] w_count;
    logic             w_tc;

    // One timer serves both intervals, so the compare value follows the state.
    assign w_tc_val = (r_state == ST_PULSE) ? PULSE_TC : TIMEOUT_TC;

    // Timer control: load 1 at the start of each interval, count inside it,
    // and hold on the finishing cycle so the count is still valid there.
    always_comb begin
        w_load  = 1'b0;
        w_en    = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = i_go;
            end
            ST_PULSE: begin
                if (w_tc) begin
                    w_load = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!i_cpu_done && !w_tc) begin
                    w_en = 1'b1;
                end else begin
                    w_en = 1'b0;
                end
            end
            ST_FINISH: begin
                w_clear = 1'b1;
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    run_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_load   (w_load),
        .i_en     (w_en),
        .i_tc_val (w_tc_val),
        .o_count  (w_count),
        .o_tc     (w_tc)
    );

    // Run FSM with all outputs registered; done wins over a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cpu_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_run_ok      <= 1'b0;
            r_run_timeout <= 1'b0;
            r_cycles      <= '0;
            r_runs        <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_run_ok      <= 1'b0;
                    r_run_timeout <= 1'b0;
                    if (i_go) begin
                        r_state     <= ST_PULSE;
                        r_cpu_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (w_tc) begin
                        r_state     <= ST_WAIT;
                        r_cpu_start <= 1'b0;
                    end else begin
                        r_state <= ST_PULSE;
                    end
                end
                ST_WAIT: begin
                    if (i_cpu_done) begin
                        r_state  <= ST_FINISH;
                        r_cycles <= w_count;
                        r_run_ok <= 1'b1;
                    end else if (w_tc) begin
                        r_state       <= ST_FINISH;
                        r_cycles      <= TIMEOUT_TC;
                        r_run_timeout <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_FINISH: begin
                    r_state       <= ST_IDLE;
                    r_busy        <= 1'b0;
                    r_run_ok      <= 1'b0;
                    r_run_timeout <= 1'b0;
                    r_runs        <= r_runs + 8'd1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cpu_start   <= 1'b0;
                    r_busy        <= 1'b0;
                    r_run_ok      <= 1'b0;
                    r_run_timeout <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_start   = r_cpu_start;
    assign o_busy        = r_busy;
    assign o_run_ok      = r_run_ok;
    assign o_run_timeout = r_run_timeout;
    assign o_cycles      = r_cycles;
    assign o_runs        = r_runs;

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. Instance "a" uses default parameters,
// instance "b" uses PULSE_CYCLES=3 and TIMEOUT_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        a_go = 1'b0, a_done = 1'b0;
    logic        a_start, a_busy, a_ok, a_to;
    logic [15:0] a_cycles;
    logic [7:0]  a_runs;

    logic        b_go = 1'b0, b_done = 1'b0;
    logic        b_start, b_busy, b_ok, b_to;
    logic [15:0] b_cycles;
    logic [7:0]  b_runs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl u_a (
        .clk (clk), .rst_n (rst_n), .i_go (a_go), .i_cpu_done (a_done),
        .o_cpu_start (a_start), .o_busy (a_busy), .o_run_ok (a_ok),
        .o_run_timeout (a_to), .o_cycles (a_cycles), .o_runs (a_runs)
    );

    cpu_run_ctrl #(.PULSE_CYCLES(3), .TIMEOUT_CYCLES(8), .CNT_W(16)) u_b (
        .clk (clk), .rst_n (rst_n), .i_go (b_go), .i_cpu_done (b_done),
        .o_cpu_start (b_start), .o_busy (b_busy), .o_run_ok (b_ok),
        .o_run_timeout (b_to), .o_cycles (b_cycles), .o_runs (b_runs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if ({a_start, a_busy, a_ok, a_to} !== 4'b0000) begin bad++; $display("FAIL reset_a_flags got=%b want=0000", {a_start, a_busy, a_ok, a_to}); end
        total++; if ({a_cycles, a_runs} !== 24'd0) begin bad++; $display("FAIL reset_a_counts got cycles=%0d runs=%0d want 0/0", a_cycles, a_runs); end
        total++; if ({b_start, b_busy, b_ok, b_to} !== 4'b0000) begin bad++; $display("FAIL reset_b_flags got=%b want=0000", {b_start, b_busy, b_ok, b_to}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", a_busy); end
    endtask

    // go for one clock, done shown during the 5th wait cycle
    task automatic test_basic_run();
        a_go = 1'b1;
        tick();
        total++; if ({a_start, a_busy} !== 2'b11) begin bad++; $display("FAIL basic_start got start/busy=%b want=11", {a_start, a_busy}); end
        a_go = 1'b0;
        tick();
        total++; if ({a_start, a_busy} !== 2'b01) begin bad++; $display("FAIL basic_pulse_width got start/busy=%b want=01", {a_start, a_busy}); end
        repeat (4) tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        total++; if ({a_ok, a_to} !== 2'b10) begin bad++; $display("FAIL basic_ok got ok/to=%b want=10", {a_ok, a_to}); end
        total++; if (a_cycles !== 16'd5) begin bad++; $display("FAIL basic_cycles got=%0d want=5", a_cycles); end
        tick();
        total++; if ({a_ok, a_busy, a_runs} !== {1'b0, 1'b0, 8'd1}) begin bad++; $display("FAIL basic_end got ok=%b busy=%b runs=%0d want 0/0/1", a_ok, a_busy, a_runs); end
    endtask

    // PULSE_CYCLES=3 with done held high the whole time
    task automatic test_pulse3_done_held();
        b_done = 1'b1;
        b_go   = 1'b1;
        tick();
        b_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if ({b_start, b_ok} !== 2'b10) begin bad++; $display("FAIL p3_pulse_%0d got start/ok=%b want=10", i, {b_start, b_ok}); end
            if (i < 2) tick();
        end
        tick();
        total++; if ({b_start, b_busy, b_ok} !== 3'b010) begin bad++; $display("FAIL p3_wait_entry got start/busy/ok=%b want=010", {b_start, b_busy, b_ok}); end
        tick();
        b_done = 1'b0;
        total++; if ({b_ok, b_cycles} !== {1'b1, 16'd1}) begin bad++; $display("FAIL p3_ok got ok=%b cycles=%0d want 1/1", b_ok, b_cycles); end
        tick();
        total++; if ({b_busy, b_runs} !== {1'b0, 8'd1}) begin bad++; $display("FAIL p3_end got busy=%b runs=%0d want 0/1", b_busy, b_runs); end
    endtask

    // TIMEOUT_CYCLES=8: no done -> timeout; then done on the 8th cycle -> ok
    task automatic test_timeout();
        int early;
        for (int run = 0; run < 2; run++) begin
            b_go = 1'b1;
            tick();
            b_go = 1'b0;
            repeat (3) tick();
            early = 0;
            for (int c = 2; c <= 8; c++) begin
                tick();
                if (b_ok || b_to || !b_busy) early++;
            end
            total++; if (early !== 0) begin bad++; $display("FAIL to_run%0d_early got=%0d early finishes want=0", run, early); end
            b_done = (run == 1);
            tick();
            b_done = 1'b0;
            total++; if ({b_ok, b_to} !== ((run == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL to_run%0d_flags got ok/to=%b want=%b", run, {b_ok, b_to}, (run == 1) ? 2'b10 : 2'b01); end
            total++; if (b_cycles !== 16'd8) begin bad++; $display("FAIL to_run%0d_cycles got=%0d want=8", run, b_cycles); end
            tick();
            total++; if ({b_busy, b_ok, b_to, b_runs} !== {3'b000, 8'd2 + 8'(run)}) begin bad++; $display("FAIL to_run%0d_end got busy=%b ok=%b to=%b runs=%0d want 0/0/0/%0d", run, b_busy, b_ok, b_to, b_runs, 2 + run); end
        end
    endtask

    // go held high: 300 back-to-back runs, exactly one idle cycle between
    task automatic test_back_to_back();
        int n_ok = 0, n_idle = 0, n_to = 0, streak = 0, long_idle = 0, cyc = 0;
        do_reset();
        a_go   = 1'b1;
        a_done = 1'b1;
        while (n_ok < 300 && cyc < 2000) begin
            tick();
            cyc++;
            if (a_to) n_to++;
            if (a_ok) n_ok++;
            if (!a_busy) begin
                n_idle++;
                streak++;
                if (streak > 1) long_idle++;
            end else begin
                streak = 0;
            end
        end
        a_go   = 1'b0;
        a_done = 1'b0;
        total++; if (n_ok !== 300) begin bad++; $display("FAIL b2b_runs_done got=%0d want=300 within budget", n_ok); end
        total++; if ({n_idle, long_idle, n_to} !== {32'd299, 32'd0, 32'd0}) begin bad++; $display("FAIL b2b_idle got idle=%0d long=%0d to=%0d want 299/0/0", n_idle, long_idle, n_to); end
        tick();
        total++; if ({a_busy, a_runs, a_cycles} !== {1'b0, 8'd44, 16'd1}) begin bad++; $display("FAIL b2b_wrap got busy=%b runs=%0d cycles=%0d want 0/44/1", a_busy, a_runs, a_cycles); end
    endtask

    // go pulses while busy must not start or queue another run
    task automatic test_go_while_busy();
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        tick();
        a_go = 1'b1; tick();
        a_go = 1'b0; tick();
        a_go = 1'b1; tick();
        a_go   = 1'b0;
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        total++; if ({a_ok, a_cycles} !== {1'b1, 16'd4}) begin bad++; $display("FAIL busy_go_ok got ok=%b cycles=%0d want 1/4", a_ok, a_cycles); end
        repeat (4) tick();
        total++; if ({a_busy, a_start, a_runs} !== {2'b00, 8'd45}) begin bad++; $display("FAIL busy_go_noqueue got busy=%b start=%b runs=%0d want 0/0/45", a_busy, a_start, a_runs); end
    endtask

    // reset mid-WAIT (a) and mid-PULSE (b), then a clean run
    task automatic test_reset_mid_run();
        a_go = 1'b1;
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        tick();
        total++; if ({a_busy, a_start, b_start} !== 3'b101) begin bad++; $display("FAIL mid_pre got a_busy/a_start/b_start=%b want=101", {a_busy, a_start, b_start}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({a_start, a_busy, b_start, b_busy} !== 4'b0000) begin bad++; $display("FAIL mid_async got=%b want=0000", {a_start, a_busy, b_start, b_busy}); end
        total++; if ({a_runs, a_cycles, b_runs, b_cycles} !== 48'd0) begin bad++; $display("FAIL mid_counts got a_runs=%0d a_cycles=%0d b_runs=%0d b_cycles=%0d want 0", a_runs, a_cycles, b_runs, b_cycles); end
        #1 rst_n = 1'b1;
        total++; if (a_start !== 1'b0) begin bad++; $display("FAIL mid_release got start=%b want=0", a_start); end
        tick();
        total++; if (a_start !== 1'b1) begin bad++; $display("FAIL mid_restart got start=%b want=1", a_start); end
        a_go = 1'b0;
        tick();
        tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        total++; if ({a_ok, a_cycles} !== {1'b1, 16'd2}) begin bad++; $display("FAIL mid_clean_ok got ok=%b cycles=%0d want 1/2", a_ok, a_cycles); end
        tick();
        total++; if ({a_busy, a_runs} !== {1'b0, 8'd1}) begin bad++; $display("FAIL mid_clean_end got busy=%b runs=%0d want 0/1", a_busy, a_runs); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_pulse3_done_held();
        test_timeout();
        test_back_to_back();
        test_go_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_run_ctrl

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 1, cpu_start high-time in clocks (legal range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum wait for cpu_done after the start pulse ends (legal range 2..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 16, width of the cycle counter and of the cycles output.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk  input  1  rising-edge system clock.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port go  input  1  run request, level-sampled in IDLE only.
REQ-008 Port cpu_done  input  1  completion flag from the cpu, synchronous to clk.
REQ-009 Port cpu_start  output  1  registered start pulse to the cpu's start input.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port run_ok  output  1  one-cycle pulse: run completed.
REQ-012 Port run_timeout  output  1  one-cycle pulse: run aborted by timeout.
REQ-013 Port cycles  output  CNT_W  wait-cycle count of the last finished run, held until the next finish.
REQ-014 Port runs  output  8  count of finished runs (ok + timeout), wraps 255->0.

Function
REQ-015 FSM states SHALL be exactly IDLE, PULSE, WAIT, FINISH; all outputs registered.
REQ-016 IDLE: go=1 at a clock edge -> PULSE on that edge, cpu_start=1 and busy=1 from that edge.
REQ-017 PULSE: cpu_start SHALL stay high exactly PULSE_CYCLES clocks, then drop as the FSM enters WAIT; cpu_done is ignored in PULSE.
REQ-018 WAIT: wait counter starts at 1 on the first WAIT cycle and increments every clock.
REQ-019 WAIT with cpu_done=1 -> FINISH; cycles <= counter value; run_ok=1 for exactly one clock.
REQ-020 WAIT with counter == TIMEOUT_CYCLES and cpu_done=0 -> FINISH; cycles <= TIMEOUT_CYCLES; run_timeout=1 for exactly one clock.
REQ-021 cpu_done=1 on the same cycle the timeout is reached SHALL count as success (run_ok, not run_timeout).
REQ-022 FINISH lasts one clock, increments runs (mod 256), then -> IDLE; run_ok and run_timeout never both high.
REQ-023 go held high continuously SHALL start a new run on the first IDLE cycle after FINISH (back-to-back runs, one idle cycle between).
REQ-024 go while busy=1 SHALL be ignored and not queued.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, cpu_start=0, busy=0, run_ok=0, run_timeout=0, cycles=0, runs=0, counter=0.
REQ-026 Reset asserted mid-PULSE or mid-WAIT SHALL drop cpu_start immediately and abandon the run without counting it.
REQ-027 After rst_n deasserts, the first run starts only on a go sampled at a subsequent clock edge.

Structure
REQ-028 Package cpu_run_pkg SHALL hold the state enum and the default constants for PULSE_CYCLES, TIMEOUT_CYCLES and CNT_W.
REQ-029 One sub-module, run_timer (load/clear, enable, terminal-count compare), SHALL implement both the pulse-width and the wait counting; no other hierarchy.

Verification
REQ-030 Reset, go=1 one clock, cpu_done raised 5 clocks after cpu_start falls -> cpu_start high 1 clock, run_ok pulse, cycles=5, runs=1.
REQ-031 PULSE_CYCLES=3, cpu_done held high throughout -> cpu_start high exactly 3 clocks; done ignored in PULSE; run_ok on first WAIT cycle, cycles=1.
REQ-032 TIMEOUT_CYCLES=8, cpu_done never asserted -> run_timeout pulse, cycles=8, runs=1, busy low one clock after FINISH; cpu_done on cycle 8 instead -> run_ok, cycles=8.
REQ-033 go held high for 300 short runs -> runs wraps to 44, one IDLE cycle between runs; go pulses while busy cause no extra runs.
REQ-034 rst_n pulled low mid-WAIT -> cpu_start/busy 0 asynchronously, runs and cycles 0, next go starts a clean run.
